// File: rtl/dir_ctrl.sv
// Direction-button conditioner for the snek core: synchronize, debounce, detect
// presses, and commit a filtered heading on the game tick.
module dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] buttons,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       turned,
  output logic       started,
  output logic [3:0] db_buttons
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       db_q, db_d;
  logic [3:0]       db_out_q;
  logic [3:0]       db_prev_q;
  logic [3:0]       press_q, press_d;
  logic [1:0]       pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       dir_q, dir_d;
  logic             turned_q, turned_d;
  logic             started_q, started_d;

  logic             req_valid;
  logic [1:0]       req;
  logic             commit;
  logic [1:0]       dir_next;
  logic             accept;

  // Counter only advances while the synchronized level disagrees with db,
  // and clears on acceptance, so it never exceeds DEBOUNCE_CYCLES-1.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      db_d[i]  = db_q[i];
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Press edges are taken from the retimed debounced level seen on db_buttons.
  always_comb begin
    press_d   = db_out_q & ~db_prev_q;
    started_d = started_q | (|press_d);
  end

  // Priority up > down > left > right; bit order is {up, down, left, right}.
  always_comb begin
    req_valid = |press_q;
    req       = 2'b11;
    if (press_q[3])      req = 2'b00;
    else if (press_q[2]) req = 2'b01;
    else if (press_q[1]) req = 2'b10;
    else                 req = 2'b11;
  end

  // Same-axis requests (same heading or its reverse) share dir bit 1.
  always_comb begin
    commit       = tick & pend_valid_q;
    dir_next     = commit ? pend_q : dir_q;
    accept       = req_valid && (req[1] != dir_next[1]);
    dir_d        = dir_next;
    turned_d     = commit;
    pend_d       = accept ? req : pend_q;
    pend_valid_d = accept | (pend_valid_q & ~commit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_q         <= '0;
      db_out_q     <= '0;
      db_prev_q    <= '0;
      press_q      <= '0;
      pend_q       <= 2'b11;
      pend_valid_q <= 1'b0;
      dir_q        <= 2'b11;
      turned_q     <= 1'b0;
      started_q    <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q      <= buttons;
      sync2_q      <= sync1_q;
      db_q         <= db_d;
      db_out_q     <= db_q;
      db_prev_q    <= db_out_q;
      press_q      <= press_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      dir_q        <= dir_d;
      turned_q     <= turned_d;
      started_q    <= started_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign dir        = dir_q;
  assign turned     = turned_q;
  assign started    = started_q;
  assign db_buttons = db_out_q;

endmodule
